// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control unit (Moore main decoder FSM plus ALU decoder)
// Ports:
//   clk, reset (async, active-low)   clock and reset
//   op, funct, zero                  IR opcode/funct fields and ALU zero flag
//   pcen, memwrite, irwrite, regwrite datapath enables (all 0 while in reset)
//   iord, memtoreg, regdst, alusrca, alusrcb, pcsrc  datapath mux selects
//   alucontrol                       ALU operation (001 also selects ORI zero-extension)
//   state                            current FSM state code for debug
module mc_controller #(
    parameter bit SUPPORT_BNE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
        BEQEX, BNEEX, ADDIEX, ORIEX, IMMWB, JEX
    } state_t;
    state_t st, nx;
    logic pcwrite, branch, bnebr;
    logic [1:0] aluop;
    always_ff @(posedge clk or negedge reset)
        if (!reset) st <= FETCH;
        else st <= nx;
    always_comb begin
        nx = FETCH;
        case (st)
            FETCH: nx = DECODE;
            DECODE:
                case (op)
                    6'b100011, 6'b101011: nx = MEMADR;
                    6'b000000: nx = RTYPEEX;
                    6'b000100: nx = BEQEX;
                    6'b000101: nx = SUPPORT_BNE ? BNEEX : FETCH;
                    6'b001000: nx = ADDIEX;
                    6'b001101: nx = ORIEX;
                    6'b000010: nx = JEX;
                    default: nx = FETCH;
                endcase
            MEMADR: nx = (op == 6'b100011) ? MEMRD : MEMWR;
            MEMRD: nx = MEMWB;
            RTYPEEX: nx = RTYPEWB;
            ADDIEX, ORIEX: nx = IMMWB;
            default: nx = FETCH;
        endcase
    end
    // Every output is gated by reset so the enables drop asynchronously.
    always_comb begin
        pcwrite = 1'b0;
        branch = 1'b0;
        bnebr = 1'b0;
        aluop = 2'b00;
        memwrite = 1'b0;
        irwrite = 1'b0;
        regwrite = 1'b0;
        iord = 1'b0;
        memtoreg = 1'b0;
        regdst = 1'b0;
        alusrca = 1'b0;
        alusrcb = 2'b00;
        pcsrc = 2'b00;
        alucontrol = 3'b000;
        if (reset) begin
            case (st)
                FETCH: begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    alusrcb = 2'b01;
                end
                DECODE: alusrcb = 2'b11;
                MEMADR, ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                MEMRD: iord = 1'b1;
                MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                MEMWR: begin
                    iord = 1'b1;
                    memwrite = 1'b1;
                end
                RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop = 2'b10;
                end
                RTYPEWB: begin
                    regdst = 1'b1;
                    regwrite = 1'b1;
                end
                BEQEX, BNEEX: begin
                    alusrca = 1'b1;
                    aluop = 2'b01;
                    pcsrc = 2'b01;
                    branch = (st == BEQEX);
                    bnebr = (st == BNEEX);
                end
                ORIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    aluop = 2'b11;
                end
                IMMWB: regwrite = 1'b1;
                JEX: begin
                    pcsrc = 2'b10;
                    pcwrite = 1'b1;
                end
                default: ;
            endcase
            // Unreachable codes 14-15 keep alucontrol at 000 like every other output.
            if (st <= JEX)
                alucontrol = (aluop == 2'b00) ? 3'b010 :
                             (aluop == 2'b01) ? 3'b110 :
                             (aluop == 2'b11) ? 3'b001 :
                             (funct == 6'b100010) ? 3'b110 :
                             (funct == 6'b100100) ? 3'b000 :
                             (funct == 6'b100101) ? 3'b001 :
                             (funct == 6'b101010) ? 3'b111 : 3'b010;
        end
    end
    assign pcen = pcwrite | (branch & zero) | (bnebr & ~zero);
    assign state = st;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized self-checking bench for mc_controller against an instruction-level model
module tb_mc_controller;
    logic clk, reset, zero, zero0;
    logic [5:0] op, funct, op0, funct0;
    logic pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic pcen0, memwrite0, irwrite0, regwrite0, iord0, memtoreg0, regdst0, alusrca0;
    logic [1:0] alusrcb0, pcsrc0;
    logic [2:0] alucontrol0;
    logic [3:0] state0;
    logic [18:0] obs;
    logic [18:0] exq[$];
    int checks = 0;
    int errors = 0;
    bit p0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
    );

    mc_controller #(.SUPPORT_BNE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .op(op0), .funct(funct0), .zero(zero0),
        .pcen(pcen0), .memwrite(memwrite0), .irwrite(irwrite0), .regwrite(regwrite0),
        .iord(iord0), .memtoreg(memtoreg0), .regdst(regdst0), .alusrca(alusrca0),
        .alusrcb(alusrcb0), .pcsrc(pcsrc0), .alucontrol(alucontrol0), .state(state0)
    );

    assign obs = {state, pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                  alusrcb, pcsrc, alucontrol};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // en = {pcen, memwrite, irwrite, regwrite}, sel = {iord, memtoreg, regdst, alusrca}
    function automatic logic [18:0] mk(input int st, input logic [3:0] en, input logic [3:0] sel,
                                       input logic [1:0] b, input logic [1:0] ps, input logic [2:0] alu);
        logic [3:0] s;
        s = st[3:0];
        return {s, en, sel, b, ps, alu};
    endfunction

    function automatic logic [2:0] alu_r(input logic [5:0] f);
        case (f)
            6'h20: return 3'b010;
            6'h22: return 3'b110;
            6'h24: return 3'b000;
            6'h25: return 3'b001;
            6'h2a: return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit known(input logic [5:0] o);
        return o inside {6'h23, 6'h2b, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0d, 6'h02};
    endfunction

    // Expected cycle-by-cycle outputs for one whole instruction, FETCH through its last state.
    function automatic void build(input logic [5:0] o, input logic [5:0] f, input bit z);
        exq.delete();
        exq.push_back(mk(0, 4'b1010, 4'b0000, 2'b01, 2'b00, 3'b010));
        exq.push_back(mk(1, 4'b0000, 4'b0000, 2'b11, 2'b00, 3'b010));
        case (o)
            6'h23: begin
                exq.push_back(mk(2, 4'b0000, 4'b0001, 2'b10, 2'b00, 3'b010));
                exq.push_back(mk(3, 4'b0000, 4'b1000, 2'b00, 2'b00, 3'b010));
                exq.push_back(mk(4, 4'b0001, 4'b0100, 2'b00, 2'b00, 3'b010));
            end
            6'h2b: begin
                exq.push_back(mk(2, 4'b0000, 4'b0001, 2'b10, 2'b00, 3'b010));
                exq.push_back(mk(5, 4'b0100, 4'b1000, 2'b00, 2'b00, 3'b010));
            end
            6'h00: begin
                exq.push_back(mk(6, 4'b0000, 4'b0001, 2'b00, 2'b00, alu_r(f)));
                exq.push_back(mk(7, 4'b0001, 4'b0010, 2'b00, 2'b00, 3'b010));
            end
            6'h04: exq.push_back(mk(8, {z, 3'b000}, 4'b0001, 2'b00, 2'b01, 3'b110));
            6'h05: exq.push_back(mk(9, {~z, 3'b000}, 4'b0001, 2'b00, 2'b01, 3'b110));
            6'h08: begin
                exq.push_back(mk(10, 4'b0000, 4'b0001, 2'b10, 2'b00, 3'b010));
                exq.push_back(mk(12, 4'b0001, 4'b0000, 2'b00, 2'b00, 3'b010));
            end
            6'h0d: begin
                exq.push_back(mk(11, 4'b0000, 4'b0001, 2'b10, 2'b00, 3'b001));
                exq.push_back(mk(12, 4'b0001, 4'b0000, 2'b00, 2'b00, 3'b010));
            end
            6'h02: exq.push_back(mk(13, 4'b1000, 4'b0000, 2'b00, 2'b10, 3'b010));
            default: ;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [18:0] o, input logic [18:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // dut0 sits on a bne opcode forever, so without bne support it bounces FETCH/DECODE.
    task automatic chk0();
        logic [3:0] e0;
        e0 = p0 ? 4'd1 : 4'd0;
        checks++;
        assert (state0 === e0) else begin
            errors++;
            $error("FAIL nobne_state observed=%0d expected=%0d", state0, e0);
        end
        p0 = ~p0;
    endtask

    task automatic run(input logic [5:0] o, input logic [5:0] f, input bit z, input int lim);
        build(o, f, z);
        for (int i = 0; i < exq.size() && i < lim; i++) begin
            @(negedge clk);
            op = o;
            funct = f;
            zero = z;
            #1;
            chk($sformatf("op%b_f%b_z%0d_cyc%0d", o, f, z, i), obs, exq[i]);
            chk0();
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        p0 = 1'b0;
    endtask

    initial begin
        logic [5:0] ops[8];
        logic [5:0] fns[5];
        logic [5:0] o, f;
        ops = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0d, 6'h02};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
        reset = 1'b0;
        op = 6'h00;
        funct = 6'h00;
        zero = 1'b0;
        op0 = 6'h05;
        funct0 = 6'h00;
        zero0 = 1'b0;
        p0 = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("reset_hold", obs, 19'd0);
        release_reset();
        run(6'h23, 6'h00, 1'b0, 99);
        run(6'h2b, 6'h00, 1'b1, 99);
        run(6'h00, 6'h2a, 1'b0, 99);
        run(6'h00, 6'h22, 1'b1, 99);
        run(6'h00, 6'h3f, 1'b0, 99);
        run(6'h04, 6'h00, 1'b1, 99);
        run(6'h04, 6'h00, 1'b0, 99);
        run(6'h05, 6'h00, 1'b0, 99);
        run(6'h05, 6'h00, 1'b1, 99);
        run(6'h08, 6'h11, 1'b0, 99);
        run(6'h0d, 6'h00, 1'b0, 99);
        run(6'h02, 6'h00, 1'b1, 99);
        run(6'h3f, 6'h00, 1'b0, 99);
        run(6'h23, 6'h00, 1'b0, 4);
        #1 reset = 1'b0;
        #1 chk("async_reset_in_memrd", obs, 19'd0);
        release_reset();
        run(6'h0d, 6'h00, 1'b0, 99);
        for (int n = 0; n < 200; n++) begin
            int k;
            k = $urandom_range(0, 8);
            if (k == 8) begin
                do o = 6'($urandom); while (known(o));
            end else o = ops[k];
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run(o, f, 1'($urandom), 99);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle MIPS control unit: a Moore main-decoder FSM plus an ALU decoder.
- Drives every select and enable of the multi-cycle datapath: PC/IR enables, register-file write, ALU source muxes, PC-source mux and ALU control.
- Consumes opcode/funct from the instruction register and the ALU zero flag.
- Its alucontrol output also feeds the sign/zero extender: ORI zero-extends when alucontrol=3'b001.

Parameters:
- SUPPORT_BNE, 1: 1 = opcode 000101 (bne) executes; 0 = bne is treated as an unknown opcode.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- op  input  6  instruction opcode, IR[31:26].
- funct  input  6  instruction funct field, IR[5:0].
- zero  input  1  ALU zero flag from the current cycle.
- pcen  output  1  PC register enable.
- memwrite  output  1  memory write enable.
- irwrite  output  1  instruction register enable.
- regwrite  output  1  register-file write enable.
- iord  output  1  memory address mux: 0 = PC, 1 = ALUOut.
- memtoreg  output  1  writeback mux: 0 = ALUOut, 1 = data register.
- regdst  output  1  write-register mux: 0 = rt, 1 = rd.
- alusrca  output  1  ALU A mux: 0 = PC, 1 = register A.
- alusrcb  output  2  ALU B mux: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- pcsrc  output  2  PC-source mux: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- alucontrol  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- state  output  4  current state code, for debug.

Behaviour:
- State register: 4 bits, async active-low reset to FETCH (0). Outputs are decoded combinationally from state, op, funct and zero only (Moore, except pcen).
- While reset=0, all enables (pcen, memwrite, irwrite, regwrite) are forced to 0 and every select/alucontrol output is 0.
- Internal signals: pcwrite, branch, bnebr, aluop[1:0].
- pcen = pcwrite | (branch & zero) | (bnebr & ~zero).
- Any signal not listed for a state is 0.
- State codes, per-state outputs and next state:
  - FETCH=0: irwrite=1, pcwrite=1, alusrcb=01, aluop=00. Next: DECODE.
  - DECODE=1: alusrcb=11, aluop=00. Next by op:
    - lw 100011 / sw 101011 -> MEMADR
    - 000000 -> RTYPEEX
    - beq 000100 -> BEQEX
    - bne 000101 -> BNEEX
    - addi 001000 -> ADDIEX
    - ori 001101 -> ORIEX
    - j 000010 -> JEX
    - any other op -> FETCH (no architectural effect)
  - MEMADR=2: alusrca=1, alusrcb=10, aluop=00. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD=3: iord=1. Next: MEMWB.
  - MEMWB=4: memtoreg=1, regwrite=1. Next: FETCH.
  - MEMWR=5: iord=1, memwrite=1. Next: FETCH.
  - RTYPEEX=6: alusrca=1, alusrcb=00, aluop=10. Next: RTYPEWB.
  - RTYPEWB=7: regdst=1, regwrite=1. Next: FETCH.
  - BEQEX=8: alusrca=1, aluop=01, pcsrc=01, branch=1. Next: FETCH.
  - BNEEX=9: as BEQEX but bnebr=1 instead of branch. Next: FETCH.
  - ADDIEX=10: alusrca=1, alusrcb=10, aluop=00. Next: IMMWB.
  - ORIEX=11: alusrca=1, alusrcb=10, aluop=11. Next: IMMWB.
  - IMMWB=12: regwrite=1 (regdst=0, memtoreg=0). Next: FETCH.
  - JEX=13: pcsrc=10, pcwrite=1. Next: FETCH.
  - Codes 14-15 are unreachable; if entered, go to FETCH with all outputs 0.
- ALU decode:
  - aluop 00 -> 010; 01 -> 110; 11 -> 001.
  - aluop 10 decodes funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Unknown funct -> 010; the RTYPEWB write still occurs.
- Latency (FETCH to FETCH): lw 5 cycles; sw, R-type, addi, ori 4; beq, bne, j 3.
- Branch taken is resolved from zero in the same cycle as BEQEX/BNEEX; no extra cycle.
- Reset asserted mid-instruction: immediate return to FETCH, enables drop asynchronously. The first rising edge after reset deasserts executes FETCH.
- op and funct are sampled only in DECODE/MEMADR/RTYPEEX; the IR is stable while irwrite=0.

Test Plan:
- Reset low for 2 cycles, release -> state=0; first cycle irwrite=1, pcen=1, alusrcb=01, alucontrol=010. Pulse reset low during MEMRD -> state=0 asynchronously, regwrite=0.
- op=100011 -> states 0,1,2,3,4,0; regwrite=1 with memtoreg=1 only in state 4; iord=1 in state 3.
- op=101011 -> states 0,1,2,5,0; memwrite=1 only in state 5; regwrite never 1.
- op=000000: funct=101010 -> alucontrol=111 in state 6, regdst=1 and regwrite=1 in state 7. Repeat with funct=100010 -> alucontrol=110.
- op=000100 with zero=1 -> pcen=1, pcsrc=01 in state 8. Same with zero=0 -> pcen=0. op=000101 with zero=0 -> pcen=1. With SUPPORT_BNE=0, op=000101 -> state 1 then 0.
- op=001101 -> state 11 alucontrol=001, then state 12 regwrite=1. op=000010 -> state 13 pcsrc=10, pcen=1. op=111111 -> 0,1,0 with no enables asserted in state 1.
